// File: rtl/kb_pkg.sv
// Shared constants, types and key lookup for the keyboard lane controller.
// Scan codes, key indices, FSM encoding and event field layout.
package kb_pkg;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam int KEY_W     = 3;
  localparam int EVT_W     = KEY_W + 1;
  localparam int NUM_LANES = 4;
  localparam int NUM_KEYS  = 5;

  localparam logic [KEY_W-1:0] KEY_A     = 3'd0;
  localparam logic [KEY_W-1:0] KEY_S     = 3'd1;
  localparam logic [KEY_W-1:0] KEY_K     = 3'd2;
  localparam logic [KEY_W-1:0] KEY_L     = 3'd3;
  localparam logic [KEY_W-1:0] KEY_ENTER = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kb_state_t;

  typedef struct packed {
    logic             hit;
    logic [KEY_W-1:0] key;
  } key_hit_t;

  typedef struct packed {
    logic             press;
    logic [KEY_W-1:0] key;
  } kb_evt_t;

  function automatic key_hit_t key_lookup(input logic [7:0] code);
    key_hit_t r;
    r = '0;
    unique case (1'b1)
      code == SC_A:     r = '{hit: 1'b1, key: KEY_A};
      code == SC_S:     r = '{hit: 1'b1, key: KEY_S};
      code == SC_K:     r = '{hit: 1'b1, key: KEY_K};
      code == SC_L:     r = '{hit: 1'b1, key: KEY_L};
      code == SC_ENTER: r = '{hit: 1'b1, key: KEY_ENTER};
      default:          r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kb_evt_fifo.sv
// First-word fall-through event FIFO with sticky overflow flag.
// Ports: push/push_data in, pop in, pop_data/full/empty/overflow out.
import kb_pkg::*;

module kb_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_data = mem[rd_ptr];

  // A pop frees the slot a simultaneous push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/kb_lane_ctrl.sv
// PS/2 set-2 decoder for four lanes plus Enter, with event FIFO.
// Ports: code_in/code_valid in; held levels, pulses, evt_* and proto_err out.
import kb_pkg::*;

module kb_lane_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int PREFIX_TIMEOUT = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           code_in,
  input  logic                 code_valid,
  output logic [NUM_LANES-1:0] lane_held,
  output logic                 enter_held,
  output logic [NUM_LANES-1:0] press_pulse,
  output logic [NUM_LANES-1:0] release_pulse,
  output logic                 enter_press,
  output logic                 evt_valid,
  output logic [EVT_W-1:0]     evt_data,
  input  logic                 evt_ready,
  output logic                 evt_overflow,
  output logic                 proto_err
);

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

  kb_state_t            state, state_d;
  logic [TW-1:0]        timer;
  logic                 armed;
  logic                 cv;
  logic                 tmo;
  logic [NUM_KEYS-1:0]  held, held_d;
  logic [NUM_LANES-1:0] press_d, rel_d;
  logic                 ent_d;
  logic                 perr_d;
  logic                 push;
  kb_evt_t              push_evt;
  logic                 do_make;
  logic                 do_break;
  key_hit_t             hit;
  logic                 fifo_empty;
  logic                 fifo_full;

  // The first edge after reset release ignores any strobe.
  assign cv  = code_valid & armed;
  assign hit = key_lookup(code_in);
  assign tmo = (state != ST_IDLE) &&
               (timer == TW'(PREFIX_TIMEOUT - 1));

  always_comb begin
    state_d  = state;
    held_d   = held;
    press_d  = '0;
    rel_d    = '0;
    ent_d    = 1'b0;
    perr_d   = 1'b0;
    push     = 1'b0;
    push_evt = '0;
    do_make  = 1'b0;
    do_break = 1'b0;

    if (cv) begin
      unique case (state)
        ST_IDLE: begin
          if (code_in == SC_BREAK)    state_d = ST_BRK;
          else if (code_in == SC_EXT) state_d = ST_EXT;
          else                        do_make = 1'b1;
        end
        ST_EXT: begin
          state_d = (code_in == SC_BREAK) ? ST_EXT_BRK
                                          : ST_IDLE;
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (code_in == SC_BREAK || code_in == SC_EXT)
            perr_d = 1'b1;
          else
            do_break = 1'b1;
        end
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if (tmo) begin
      state_d = ST_IDLE;
      perr_d  = 1'b1;
    end

    if (do_make && hit.hit && !held[hit.key]) begin
      held_d[hit.key] = 1'b1;
      if (hit.key == KEY_ENTER) ent_d = 1'b1;
      else press_d[hit.key[1:0]] = 1'b1;
      push     = 1'b1;
      push_evt = '{press: 1'b1, key: hit.key};
    end

    if (do_break && hit.hit && held[hit.key]) begin
      held_d[hit.key] = 1'b0;
      if (hit.key != KEY_ENTER) rel_d[hit.key[1:0]] = 1'b1;
      push     = 1'b1;
      push_evt = '{press: 1'b0, key: hit.key};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      timer         <= '0;
      armed         <= 1'b0;
      held          <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      enter_press   <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      state         <= state_d;
      armed         <= 1'b1;
      held          <= held_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
      enter_press   <= ent_d;
      proto_err     <= perr_d;
      if (cv || state == ST_IDLE || tmo) timer <= '0;
      else                               timer <= timer + 1'b1;
    end
  end

  assign lane_held  = held[NUM_LANES-1:0];
  assign enter_held = held[KEY_ENTER];
  assign evt_valid  = ~fifo_empty;

  kb_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_evt),
    .pop       (evt_ready),
    .pop_data  (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (evt_overflow)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/kb_lane_ctrl.md
KB_LANE_CTRL -- requirements
Module: kb_lane_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sets event FIFO depth; power of two, 4..16.
REQ-002 Parameter PREFIX_TIMEOUT, default 2_000_000, is the number of clk cycles a pending prefix waits for the next byte before it is abandoned.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 code_in  input  8  PS/2 set-2 byte from the keyboard receiver.
REQ-006 code_valid  input  1  one-cycle strobe; code_in is valid in that cycle.
REQ-007 lane_held  output  4  level per lane, bit0..3 = A,S,K,L currently pressed.
REQ-008 enter_held  output  1  Enter currently pressed.
REQ-009 press_pulse  output  4  one-cycle pulse per lane on a new press.
REQ-010 release_pulse  output  4  one-cycle pulse per lane on release.
REQ-011 enter_press  output  1  one-cycle pulse on a new Enter press.
REQ-012 evt_valid  output  1  FIFO non-empty.
REQ-013 evt_data  output  4  head event {press(1=down), key[2:0]}; key 0..3 = lanes, 4 = Enter.
REQ-014 evt_ready  input  1  consumer pops the head when evt_valid and evt_ready are both high.
REQ-015 evt_overflow  output  1  sticky flag: an event was dropped.
REQ-016 proto_err  output  1  one-cycle pulse on a malformed prefix sequence or a prefix timeout.

Function
REQ-017 Key map: A=0x1C, S=0x1B, K=0x42, L=0x4B, Enter=0x5A; prefixes BREAK=0xF0, EXT=0xE0.
REQ-018 FSM states IDLE, BRK, EXT, EXT_BRK; code_valid is the only trigger apart from the timeout.
REQ-019 IDLE: F0->BRK, E0->EXT; any other byte is processed as a make code, then stay IDLE.
REQ-020 EXT: F0->EXT_BRK; any other byte is discarded, ->IDLE.
REQ-021 BRK: E0 or F0 ->IDLE with proto_err; any other byte is processed as a break code, ->IDLE.
REQ-022 EXT_BRK: any byte is discarded, ->IDLE; extended keys (e.g. E0 5A) never affect outputs.
REQ-023 Make of an unheld mapped key: set its held bit, pulse press_pulse or enter_press, push {1,key}.
REQ-024 Make of an already-held key (typematic repeat): no pulse, no event.
REQ-025 Break of a held mapped key: clear its held bit, pulse release_pulse (lanes only), push {0,key}.
REQ-026 Break of an unheld key, and any unmapped code (0xAA, 0xFA, ...): ignored.
REQ-027 Latency: a byte strobed in cycle N updates held bits, pulses and FIFO contents visibly in cycle N+1, with all of them registered.
REQ-028 At most one event is pushed per code_valid.
REQ-029 Prefix timer: reloads on every code_valid and counts only in BRK/EXT/EXT_BRK; on reaching PREFIX_TIMEOUT it forces IDLE and pulses proto_err.
REQ-030 FIFO is first-word fall-through: evt_data reflects the head whenever evt_valid is high.
REQ-031 Push when full with no pop: the event is dropped, contents are unchanged, evt_overflow is set.
REQ-032 Simultaneous push and pop when full: both succeed, count is unchanged, no overflow.
REQ-033 Pop when empty: ignored; pointers wrap modulo FIFO_DEPTH.
REQ-034 evt_overflow clears only on reset.

Reset
REQ-035 Asserting rst immediately forces: FSM to IDLE, timer to 0, lane_held=0, enter_held=0, all pulses 0, FIFO empty (evt_valid=0), evt_overflow=0, proto_err=0.
REQ-036 Reset during a prefix sequence discards it; the first byte after deassertion is decoded from IDLE.
REQ-037 A code_valid in the same cycle rst deasserts is ignored.

Structure
REQ-038 Package kb_pkg holds the scan-code constants, the key-index constants (KEY_A..KEY_ENTER), the FSM state encoding, and the event field widths.
REQ-039 The event FIFO is sub-module kb_evt_fifo (parameter DEPTH, WIDTH=4, push/pop/full/empty/overflow); decode and FSM stay in kb_lane_ctrl.

Verification
REQ-040 Bytes 1C, F0 1C -> lane_held[0] high from cycle after 1C; press_pulse[0] once, release_pulse[0] once; events {1,0},{0,0}.
REQ-041 1C x5 (typematic), then F0 1C -> one press event and one release event only; lane_held[0] stays high throughout the repeats.
REQ-042 E0 5A, then E0 F0 5A -> enter_held remains 0, no events; a following 5A -> enter_press, event {1,4}.
REQ-043 evt_ready=0, 9 distinct press/release events with FIFO_DEPTH=8 -> 8 stored, evt_overflow=1, head={1,0}; simultaneous push+pop while full -> no new overflow, count stays 8.
REQ-044 F0 then idle PREFIX_TIMEOUT cycles -> proto_err pulse, FSM IDLE; following 1B -> treated as make, press_pulse[1].
REQ-045 Hold A and K, pulse rst low mid F0 sequence -> all held bits and FIFO cleared at once; next 42 -> press_pulse[2].
